// File: rtl/psum_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : psum_bank_ctrl
//  Description : Controller for the single-port psum output bank. Writes the
//                SFU writeback stream into the bank in order. Arbitrates bank
//                access against host reads, with a starvation guard for reads.
//                Counts output words and flags completion of a convolution.
//  Revision    : 1.0 - initial release
// ============================================================================
module psum_bank_ctrl #(
   parameter int COL        = 8,
   parameter int PSUM_BW    = 16,
   parameter int LEN_ONIJ   = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      sfu_valid,
   input  logic [COL*PSUM_BW-1:0]    sfu_data,
   output logic                      sfu_ready,
   input  logic                      rd_req,
   input  logic [ADDR_WIDTH-1:0]     rd_addr,
   output logic                      rd_ready,
   output logic [COL*PSUM_BW-1:0]    rd_data,
   output logic                      rd_data_valid,
   output logic                      rd_err,
   output logic                      mem_en,
   output logic                      mem_wen,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [COL*PSUM_BW-1:0]    mem_din,
   input  logic [COL*PSUM_BW-1:0]    mem_dout,
   output logic                      busy,
   output logic                      conv_done,
   output logic [ADDR_WIDTH:0]       wr_count
);

   // Starvation counter only needs to reach STARVE_MAX.
   localparam int                    c_starve_w   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_MAX);
   localparam logic [ADDR_WIDTH:0]   c_len_cnt    = (ADDR_WIDTH + 1)'(LEN_ONIJ);
   localparam logic [31:0]           c_len_addr   = 32'(LEN_ONIJ);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t                  r_state;
   logic [ADDR_WIDTH:0]     r_wr_count;
   logic [c_starve_w-1:0]   r_starve_cnt;
   logic                    r_conv_done;
   logic                    r_rd_data_valid;
   logic                    r_rd_err;

   logic                    w_force_rd;
   logic                    w_sfu_ready;
   logic                    w_write_go;
   logic                    w_rd_grant;
   logic                    w_rd_in_range;
   logic [ADDR_WIDTH:0]     w_wr_count_inc;

   // A starved reader takes the bank away from the writer for one cycle.
   assign w_force_rd     = (r_starve_cnt == c_starve_max) & rd_req;
   assign w_sfu_ready    = (r_state == S_WRITE) & ~w_force_rd;
   assign w_write_go     = sfu_valid & w_sfu_ready;
   assign w_rd_grant     = rd_req & ~w_write_go;
   assign w_rd_in_range  = (32'(rd_addr) < c_len_addr);
   assign w_wr_count_inc = r_wr_count + 1'b1;

   // Bank drive: at most one access per cycle; out-of-range reads never touch the bank.
   assign mem_en   = w_write_go | (w_rd_grant & w_rd_in_range);
   assign mem_wen  = w_write_go;
   assign mem_addr = w_write_go ? r_wr_count[ADDR_WIDTH-1:0] : rd_addr;
   assign mem_din  = sfu_data;

   assign sfu_ready     = w_sfu_ready;
   assign rd_ready      = w_rd_grant;
   assign rd_data       = mem_dout;
   assign rd_data_valid = r_rd_data_valid;
   assign rd_err        = r_rd_err;
   assign busy          = (r_state == S_WRITE);
   assign conv_done     = r_conv_done;
   assign wr_count      = r_wr_count;

   // Writeback sequencer: IDLE -> WRITE on start, WRITE -> DONE on the last word.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_wr_count  <= '0;
         r_conv_done <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_WRITE;
                  r_wr_count <= '0;
               end
            end
            S_WRITE: begin
               if (w_write_go) begin
                  r_wr_count <= w_wr_count_inc;
                  if (w_wr_count_inc == c_len_cnt) begin
                     r_state     <= S_DONE;
                     r_conv_done <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (start) begin
                  r_state     <= S_WRITE;
                  r_wr_count  <= '0;
                  r_conv_done <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Read response pipeline and read-starvation counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_starve_cnt    <= '0;
         r_rd_data_valid <= 1'b0;
         r_rd_err        <= 1'b0;
      end else begin
         r_rd_data_valid <= w_rd_grant & w_rd_in_range;
         r_rd_err        <= w_rd_grant & ~w_rd_in_range;
         if (!rd_req || w_rd_grant) begin
            r_starve_cnt <= '0;
         end else if (r_starve_cnt != c_starve_max) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_psum_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_bank_ctrl
//  Description : Scoreboard bench for psum_bank_ctrl with a behavioural bank
//                model, directed scenarios and a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_bank_ctrl;

   localparam int COL = 8;
   localparam int PSUM_BW = 16;
   localparam int LEN = 16;
   localparam int AW = 5;
   localparam int SM = 3;
   localparam int DW = COL * PSUM_BW;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset = 1'b0;
   logic            start = 1'b0;
   logic            sfu_valid = 1'b0;
   logic [DW-1:0]   sfu_data = '0;
   logic            sfu_ready;
   logic            rd_req = 1'b0;
   logic [AW-1:0]   rd_addr = '0;
   logic            rd_ready;
   logic [DW-1:0]   rd_data;
   logic            rd_data_valid;
   logic            rd_err;
   logic            mem_en;
   logic            mem_wen;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_din;
   logic [DW-1:0]   mem_dout;
   logic            busy;
   logic            conv_done;
   logic [AW:0]     wr_count;

   psum_bank_ctrl #(
      .COL(COL), .PSUM_BW(PSUM_BW), .LEN_ONIJ(LEN), .ADDR_WIDTH(AW), .STARVE_MAX(SM)
   ) dut (
      .clk(clk), .reset(reset), .start(start),
      .sfu_valid(sfu_valid), .sfu_data(sfu_data), .sfu_ready(sfu_ready),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
      .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_err(rd_err),
      .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_din(mem_din), .mem_dout(mem_dout),
      .busy(busy), .conv_done(conv_done), .wr_count(wr_count)
   );

   // Single-port SRAM seen by the DUT: one-cycle read latency.
   logic [DW-1:0] bank [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_en && mem_wen)  bank[mem_addr] <= mem_din;
      if (mem_en && !mem_wen) mem_dout <= bank[mem_addr];
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      bit            err;
      bit            known;
      logic [DW-1:0] data;
      int            due;
   } exp_t;
   exp_t q[$];

   // Reference model: state as plain integers (0 idle, 1 writing, 2 done).
   int            m_state = 0;
   int            m_cnt = 0;
   int            m_starve = 0;
   bit            m_done = 0;
   logic [DW-1:0] m_mem [LEN];
   bit            m_wr [LEN];

   task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // One clock cycle: drive, check combinational response, push expected reads, advance model.
   task automatic step(bit rn, bit st, bit sv, logic [DW-1:0] sd, bit rq, logic [AW-1:0] ra);
      bit   f, er, ew, rr, inr;
      exp_t e;
      @(negedge clk);
      reset = rn; start = st; sfu_valid = sv; sfu_data = sd; rd_req = rq; rd_addr = ra;
      #1;
      f   = (m_starve == SM) && rq;
      er  = (m_state == 1) && !f;
      ew  = sv && er;
      rr  = rq && !ew;
      inr = (int'(ra) < LEN);
      chk("sfu_ready", sfu_ready, er);
      chk("rd_ready", rd_ready, rr);
      chk("busy", busy, (m_state == 1));
      chk("conv_done", conv_done, m_done);
      chk("wr_count", wr_count, m_cnt);
      chk("mem_en", mem_en, ew || (rr && inr));
      if (ew) begin
         chk("mem_wen", mem_wen, 1'b1);
         chk("wr_addr", mem_addr, m_cnt);
         chk("mem_din", mem_din, sd);
      end else if (rr && inr) begin
         chk("mem_wen", mem_wen, 1'b0);
         chk("rd_addr_out", mem_addr, ra);
      end
      if (rn && rr) begin
         e.err   = !inr;
         e.known = inr && m_wr[inr ? int'(ra) : 0];
         e.data  = inr ? m_mem[int'(ra)] : '0;
         e.due   = cyc + 1;
         q.push_back(e);
      end
      if (!rn) begin
         m_state = 0; m_cnt = 0; m_starve = 0; m_done = 0;
      end else begin
         if (ew) begin
            m_mem[m_cnt] = sd;
            m_wr[m_cnt]  = 1'b1;
            m_cnt++;
            if (m_cnt == LEN) begin
               m_state = 2; m_done = 1;
            end
         end else if (st && m_state != 1) begin
            m_state = 1; m_cnt = 0; m_done = 0;
         end
         if (!rq || rr) m_starve = 0;
         else if (m_starve < SM) m_starve++;
      end
      @(posedge clk);
   endtask

   function automatic logic [DW-1:0] rnd();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Monitor: compares every read response against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (rd_data_valid || rd_err) begin
            if (q.size() == 0) begin
               chk("spurious_rd_resp", rd_data_valid | rd_err, 1'b0);
            end else begin
               e = q.pop_front();
               chk("rd_latency", cyc, e.due);
               chk("rd_err", rd_err, e.err);
               chk("rd_data_valid", rd_data_valid, !e.err);
               if (!e.err && e.known) chk("rd_data", rd_data, e.data);
            end
         end else if (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("rd_resp_missing", rd_data_valid | rd_err, 1'b1);
         end
      end
   end

   initial begin
      for (int i = 0; i < LEN; i++) m_wr[i] = 1'b0;
      @(posedge clk);
      // Reset held low for two cycles.
      step(0, 0, 0, '0, 0, '0);
      step(0, 0, 0, '0, 0, '0);
      // Full convolution with back-to-back words.
      step(1, 1, 0, '0, 0, '0);
      for (int i = 0; i < LEN; i++) step(1, 0, 1, rnd(), 0, '0);
      step(1, 0, 1, rnd(), 0, '0);
      step(1, 0, 0, '0, 0, '0);
      // Back-to-back readout.
      for (int a = 0; a < LEN; a++) step(1, 0, 0, '0, 1, AW'(a));
      step(1, 0, 0, '0, 0, '0);
      // Starvation: continuous writes against held read requests; stray start mid-write.
      step(1, 1, 0, '0, 0, '0);
      for (int i = 0; i < 40 && m_state != 2; i++)
         step(1, (i == 5), 1, rnd(), 1, AW'($urandom % LEN));
      step(1, 0, 0, '0, 0, '0);
      // Out-of-range read in DONE.
      step(1, 0, 0, '0, 1, AW'(20));
      step(1, 0, 0, '0, 0, '0);
      // Reset after seven writes with a read in flight.
      step(1, 1, 0, '0, 0, '0);
      for (int i = 0; i < 7; i++) step(1, 0, 1, rnd(), 0, '0);
      step(1, 0, 0, '0, 1, AW'(3));
      step(0, 0, 1, rnd(), 1, AW'(4));
      step(1, 0, 0, '0, 0, '0);
      step(1, 1, 0, '0, 0, '0);
      for (int i = 0; i < LEN; i++) step(1, 0, 1, rnd(), 0, '0);
      // Restart from DONE, with simultaneous read.
      step(1, 1, 0, '0, 1, AW'(2));
      for (int i = 0; i < 3; i++) step(1, 0, 1, rnd(), 0, '0);
      // Randomized traffic.
      for (int i = 0; i < 700; i++)
         step(($urandom % 250) != 0, ($urandom % 20) == 0, ($urandom % 4) != 0, rnd(),
              ($urandom % 3) == 0, AW'($urandom % 24));
      for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 0, '0);
      chk("scoreboard_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/psum_bank_ctrl.md
Name: psum_bank_ctrl

Overview:
- Sequences the single-port psum output bank fed by the SFU writeback stream.
- Arbitrates bank access between that stream (write) and a host readout requester (read).
- Tracks the per-convolution output count (len_onij words) and flags completion.
- Sits between the SFU writeback stage and the psum SRAM; the host drains results through its read port.

Parameters:
col, 8, output channels per psum word
psum_bw, 16, bits per psum lane
len_onij, 16, psum words per convolution (output pixels)
addr_width, 4, bank address width, must be >= $clog2(len_onij)
starve_max, 3, consecutive blocked read cycles before a read is forced

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous active-low reset (0 = reset)
start  in  1  one-cycle pulse, begin a new convolution writeback
sfu_valid  in  1  SFU psum word valid
sfu_data  in  col*psum_bw  SFU psum word
sfu_ready  out  1  write accepted this cycle when sfu_valid & sfu_ready
rd_req  in  1  host read request
rd_addr  in  addr_width  host read address
rd_ready  out  1  read granted this cycle when rd_req & rd_ready
rd_data  out  col*psum_bw  read data (= mem_dout)
rd_data_valid  out  1  rd_data valid, one cycle after grant
rd_err  out  1  pulse, one cycle after an out-of-range grant
mem_en  out  1  bank enable
mem_wen  out  1  1 = write, 0 = read (meaningful only when mem_en=1)
mem_addr  out  addr_width  bank address
mem_din  out  col*psum_bw  bank write data
mem_dout  in  col*psum_bw  bank read data, valid one cycle after a read enable
busy  out  1  state == WRITE
conv_done  out  1  all len_onij words written
wr_count  out  addr_width+1  words written in current convolution

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, wr_count=0, starve_cnt=0, conv_done=0, rd_data_valid=0, rd_err=0.
  - Combinational outputs follow from these: sfu_ready=0, mem_en=0, busy=0.
  - Reset mid-operation drops any in-flight read; no rd_data_valid or rd_err follows.
- FSM states IDLE, WRITE, DONE:
  - IDLE: start -> WRITE. wr_count cleared to 0.
  - WRITE: each write handshake writes sfu_data at mem_addr=wr_count[addr_width-1:0], then wr_count++.
    - The handshake that makes wr_count==len_onij moves to DONE.
    - start is ignored in WRITE.
  - DONE: conv_done=1 (registered; asserts the cycle after the last write). sfu_ready=0.
    - start -> WRITE, with wr_count=0 and conv_done=0 on the next cycle.
- sfu_ready = (state==WRITE) & ~force_rd. Combinational; it does not depend on sfu_valid.
- Arbitration:
  - force_rd = (starve_cnt==starve_max) & rd_req.
  - write_go = sfu_valid & sfu_ready.
  - rd_ready = rd_req & ~write_go. Writes win unless force_rd is set.
- starve_cnt:
  - Increments when rd_req & ~rd_ready, saturating at starve_max.
  - Clears on a read grant, or when rd_req==0.
- Bank drive:
  - write_go: mem_en=1, mem_wen=1, mem_din=sfu_data.
  - In-range read grant: mem_en=1, mem_wen=0, mem_addr=rd_addr.
  - Otherwise mem_en=0.
  - At most one access per cycle.
- Reads are allowed in every state. A read of an address >= wr_count in WRITE returns stale bank contents; no check is made.
- Out-of-range read (rd_addr >= len_onij): still granted, no bank access, rd_err=1 the next cycle, rd_data_valid=0.
- Read latency: grant at cycle N -> rd_data_valid=1 at N+1, rd_data = mem_dout. Back-to-back grants give back-to-back valids.
- Simultaneous start and read in IDLE/DONE: both take effect; the read is granted because write_go=0 that cycle.
- sfu_valid outside WRITE: ignored, no write.

Test Plan:
- Reset low 2 cycles, then start and 16 back-to-back sfu_valid words D0..D15 -> mem writes at addr 0..15 on consecutive cycles; wr_count=16; conv_done rises the cycle after D15; sfu_ready=0 afterwards.
- After done, read addr 0..15 back-to-back -> rd_ready=1 every cycle; rd_data_valid 1 cycle later; rd_data=D0..D15 in order.
- starve_max=3: continuous sfu_valid plus rd_req held -> rd_ready=0 for 3 cycles, 4th cycle rd_ready=1, sfu_ready=0, mem_wen=0. Write resumes the next cycle; wr_count does not increment in the forced cycle.
- rd_addr=20 in DONE -> rd_ready=1, mem_en=0, rd_err=1 next cycle, rd_data_valid=0.
- Reset asserted after 7 writes with a read in flight -> next cycle state IDLE, wr_count=0, rd_data_valid=0, conv_done=0. A following start restarts at addr 0.
- In DONE, pulse start -> conv_done=0 next cycle, busy=1, next write goes to addr 0. A start pulsed during WRITE has no effect on wr_count.
